// File: rtl/key_debounce_pkg.sv
// ----------------------------------------------------------------------
// key_debounce_pkg : shared FSM encoding and debounce-limit helper. rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package key_debounce_pkg;

  typedef enum logic [1:0] {
    REL      = 2'd0,
    REL_FILT = 2'd1,
    PRS      = 2'd2,
    PRS_FILT = 2'd3
  } state_t;

  function automatic int cnt_max(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// ----------------------------------------------------------------------
// key_debounce_ch : one key channel - 2-FF sync, filter FSM, pulses. rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int CNT_MAX = 10,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_stable,
  output logic key_press,
  output logic key_release
);

  // The entry sample into a FILT state is the first of CNT_MAX, so the
  // filter fires on the sample that would move cnt up to CNT_MAX-1.
  localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(CNT_MAX - 2);

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      state       <= REL;
      cnt         <= '0;
      key_stable  <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      s1          <= key_in;
      s2          <= s1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        REL: begin
          cnt <= '0;
          if (!s2) state <= REL_FILT;
        end
        REL_FILT: begin
          if (s2) begin
            cnt   <= '0;
            state <= REL;
          end else if (cnt == FIRE_AT) begin
            cnt        <= '0;
            state      <= PRS;
            key_stable <= 1'b0;
            key_press  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRS: begin
          cnt <= '0;
          if (s2) state <= PRS_FILT;
        end
        PRS_FILT: begin
          if (!s2) begin
            cnt   <= '0;
            state <= PRS;
          end else if (cnt == FIRE_AT) begin
            cnt         <= '0;
            state       <= REL;
            key_stable  <= 1'b1;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= REL;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------
// key_debounce : NUM_KEYS independent debounced key channels. rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS    = 3,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_stable,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int CNT_MAX = cnt_max(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  generate
    if (CNT_MAX < 2) begin : g_bad_cnt_max
      $error("key_debounce: CNT_MAX must be at least 2");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
      ) u_ch (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .key_in      (key_in[i]),
        .key_stable  (key_stable[i]),
        .key_press   (key_press[i]),
        .key_release (key_release[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ----------------------------------------------------------------------
// tb_key_debounce : directed + random checks against a run-length model. rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_key_debounce;

  localparam int N       = 3;
  localparam int CNT_MAX = 1000 / 1000 * 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_in = '1;
  logic [N-1:0] key_stable;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;

  key_debounce #(
    .NUM_KEYS    (N),
    .CLK_FREQ_HZ (1000),
    .DEBOUNCE_MS (10)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (rst),
    .key_in      (key_in),
    .key_stable  (key_stable),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: two-sample pin delay, then a level flips once CNT_MAX
  // consecutive synchronised samples disagree with it.
  logic [N-1:0] m_s1 = '1;
  logic [N-1:0] m_s2 = '1;
  logic [N-1:0] m_stable = '1;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_release = '0;
  int           m_run [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] k;
    logic         r;
    k = key_in;
    r = rst;
    @(posedge clk);
    #1;
    if (r) begin
      m_s1 = '1; m_s2 = '1; m_stable = '1; m_press = '0; m_release = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        m_press[i]   = 1'b0;
        m_release[i] = 1'b0;
        if (m_s2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == CNT_MAX) begin
            m_stable[i] = ~m_stable[i];
            if (m_stable[i]) m_release[i] = 1'b1;
            else             m_press[i]   = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = k;
    end
    check("model_stable",  32'(key_stable),  32'(m_stable));
    check("model_press",   32'(key_press),   32'(m_press));
    check("model_release", 32'(key_release), 32'(m_release));
  endtask

  // Steps until the chosen pulse appears; n = cycles taken, 0 if none in budget.
  task automatic wait_pulse(input int k, input bit rel, output int n);
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (rel ? key_release[k] : key_press[k]) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p;
    for (int i = 0; i < N; i++) m_run[i] = 0;

    // 1: reset then idle
    @(posedge clk); #1;
    rst = 1'b1;
    step(); step();
    check("reset_stable",  32'(key_stable),  32'(3'b111));
    check("reset_press",   32'(key_press),   32'(3'b000));
    check("reset_release", 32'(key_release), 32'(3'b000));
    rst = 1'b0;
    repeat (50) step();
    check("idle_stable", 32'(key_stable), 32'(3'b111));

    // 2: clean press and release on key 0
    key_in[0] = 1'b0;
    wait_pulse(0, 1'b0, n);
    check("k0_press_latency", 32'(n), 32'd12);
    check("k0_stable_low", 32'(key_stable), 32'(3'b110));
    step();
    check("k0_press_width", 32'(key_press), 32'(3'b000));
    repeat (5) step();
    key_in[0] = 1'b1;
    wait_pulse(0, 1'b1, n);
    check("k0_release_latency", 32'(n), 32'd12);
    check("k0_stable_high", 32'(key_stable), 32'(3'b111));

    // 3: key 1 bouncing every 4 cycles, then held low
    repeat (3) step();
    p = 0;
    for (int c = 0; c < 100; c++) begin
      if (c % 4 == 0) key_in[1] = ~key_in[1];
      step();
      if (key_press[1] || key_release[1]) p++;
    end
    key_in[1] = 1'b1;
    repeat (4) begin step(); if (key_press[1] || key_release[1]) p++; end
    check("k1_bounce_pulses", 32'(p), 32'd0);
    check("k1_bounce_stable", 32'(key_stable), 32'(3'b111));
    key_in[1] = 1'b0;
    wait_pulse(1, 1'b0, n);
    check("k1_press_latency", 32'(n), 32'd12);
    key_in[1] = 1'b1;
    wait_pulse(1, 1'b1, n);
    check("k1_release_latency", 32'(n), 32'd12);

    // 4: 9-cycle glitch rejected, 10-cycle pulse accepted on key 2
    repeat (3) step();
    key_in[2] = 1'b0;
    repeat (9) step();
    key_in[2] = 1'b1;
    p = 0;
    repeat (20) begin step(); if (key_press[2]) p++; end
    check("k2_short_pulses", 32'(p), 32'd0);
    check("k2_short_stable", 32'(key_stable), 32'(3'b111));
    key_in[2] = 1'b0;
    n = 0;
    p = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 10) key_in[2] = 1'b1;
      if (key_press[2]) begin
        p++;
        if (n == 0) n = c;
      end
    end
    check("k2_min_press_latency", 32'(n), 32'd12);
    check("k2_min_press_count", 32'(p), 32'd1);
    repeat (15) step();
    check("k2_back_high", 32'(key_stable), 32'(3'b111));

    // 5: all keys pressed on the same edge
    key_in = '0;
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (key_press != '0) begin
        n = c;
        break;
      end
    end
    check("all_press_latency", 32'(n), 32'd12);
    check("all_press_bits", 32'(key_press), 32'(3'b111));
    check("all_stable_and", 32'(&key_stable), 32'd0);
    key_in = '1;
    repeat (20) step();
    check("all_released", 32'(key_stable), 32'(3'b111));

    // 6: reset in the middle of filtering key 0
    key_in[0] = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    step();
    check("midrst_stable",  32'(key_stable),  32'(3'b111));
    check("midrst_press",   32'(key_press),   32'(3'b000));
    check("midrst_release", 32'(key_release), 32'(3'b000));
    rst = 1'b0;
    wait_pulse(0, 1'b0, n);
    check("midrst_repress_latency", 32'(n), 32'd12);
    key_in[0] = 1'b1;
    repeat (20) step();

    // random bouncing with occasional resets
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) key_in[i] = ~key_in[i];
      rst = ($urandom_range(0, 199) == 0);
      step();
      check("rand_no_both", 32'(key_press & key_release), 32'd0);
    end
    rst = 1'b0;
    key_in = '1;
    repeat (20) step();
    check("final_stable", 32'(key_stable), 32'(3'b111));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
